mmio_input_port: RTL and testbench
==================================

Name: mmio_input_port

Overview:
- Memory-mapped input responder on the core's data-memory port: the read-side counterpart of the LED store latch.
- Synchronises the Basys3 slide switches and push buttons, debounces the buttons, and records sticky press events.
- Returns register contents to core loads on the same bus signals the core drives for stores (address, write enable, write data).
- Sits in fpga_top beside the data memory. The top-level read mux selects this block's read data whenever sel is high.

Parameters:
- BASE_ADDR, 32'h0000_0100, base of the 16-byte register window; bits [3:0] must be zero.
- N_SW, 16, number of slide switches.
- N_BTN, 5, number of push buttons.
- DEBOUNCE_CYCLES, 1_000_000, cycles a button must hold stable before it is accepted (10 ms at 100 MHz); must be ≥2.

Ports:
- clk  in  1  system clock (CLK100MHZ domain).
- rst_n  in  1  asynchronous active-low reset.
- sw_i  in  N_SW  raw switch pins, asynchronous.
- btn_i  in  N_BTN  raw button pins, asynchronous, active-high.
- addr  in  32  byte address (core ALUResultM).
- mem_write  in  1  store strobe (core MemWriteM).
- wdata  in  32  store data (core WriteDataM).
- sel  out  1  combinational: addr falls in the window.
- rdata  out  32  combinational read data.
- irq  out  1  press-event interrupt; present only when the feature is enabled, otherwise tied 0.

Behaviour:
- Reset is asynchronous and active-low; all flops clear.
  - Synchroniser stages, debounced state, debounce counters, edge flags and mask reset to 0.
  - rdata reads 0 for any in-window address; irq is 0.
- Synchronisation: two-flop synchroniser on every sw_i and btn_i bit. Switch value is visible at register SW 2 cycles after a pin change.
- Debounce, per button (independent counter, width $clog2(DEBOUNCE_CYCLES)):
  - State IDLE (sync == deb): counter held at 0.
  - State COUNT (sync != deb): counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != deb, deb <= sync and the counter returns to 0.
  - A glitch back to the old value before then returns the counter to 0 (IDLE). Counter never wraps.
- Edge capture: a 0→1 transition of deb sets EDGE[i] in the same cycle deb updates. Release (1→0) sets nothing.
- Decode: sel = (addr[31:4] == BASE_ADDR[31:4]). Offset is addr[3:2]; addr[1:0] is ignored (word access only).
- Register map. Unused upper bits read 0; out-of-window addr gives rdata = 0.
  - 0x0: SW, read-only, synced switches.
  - 0x4: BTN, read-only, debounced buttons.
  - 0x8: EDGE, sticky press flags, write-1-to-clear from wdata[N_BTN-1:0].
  - 0xC: MASK, see Optional Feature; otherwise reads 0 and writes are ignored.
- Writes take effect on the clk edge where mem_write && sel.
  - Writes to read-only offsets are ignored.
- Read latency: zero (combinational from registers), matching the data-memory timing of the core's M stage.
- Simultaneous W1C and new press on the same bit: set wins, so the flag stays 1.
- Reset asserted mid-debounce discards the count. After release, a held button needs a full DEBOUNCE_CYCLES again.

Optional Feature:
- Macro: MMIO_INPUT_IRQ_EN.
- Defined:
  - MASK register at 0xC, N_BTN bits, read/write, reset 0.
  - irq = |(EDGE & MASK), registered (asserts 1 cycle after the flag or mask condition becomes true).
  - irq deasserts 1 cycle after a W1C that clears all masked flags.
- Undefined: no MASK flops; offset 0xC reads 0; irq tied 0.

Decomposition:
- Package mmio_in_pkg:
  - Offset constants OFF_SW=2'd0, OFF_BTN=2'd1, OFF_EDGE=2'd2, OFF_MASK=2'd3.
  - typedef enum {DB_IDLE, DB_COUNT} db_state_e.
  - Register-map width constants.
- Sub-module input_debounce: one button, synchroniser plus counter plus deb output plus rise pulse. Instantiated N_BTN times via generate.
- Switch synchronisers stay inline.

Test Plan (sim with DEBOUNCE_CYCLES=4):
- Switch sync: sw_i=16'hA5C3 → load at 0x100 returns 32'h0000_A5C3 from the 3rd clk edge on; sel=1.
- Debounce accept: btn_i[0] held 1 → BTN reads 0 through the edge at which the count reaches 3, then reads 5'b00001; EDGE reads 5'b00001.
- Glitch reject: btn_i[1] high for 2 cycles then low → BTN and EDGE stay 0; counter returns to 0.
- W1C race: EDGE=5'b00001, store 32'h1 to 0x108 on the same edge that btn_i[2] is accepted → EDGE reads 5'b00100. A second store of 32'h4 → EDGE reads 0.
- Decode and reset: a load at 0x110 gives sel=0, rdata=0. A store to 0x100 leaves SW unchanged. rst_n pulsed low mid-count → all registers 0 and a full debounce is needed after release.
- With MMIO_INPUT_IRQ_EN: MASK=5'b00010, press btn[1] → irq=1 one cycle after EDGE[1] sets; W1C of 32'h2 → irq=0 next cycle. Press btn[0] with the same mask → irq stays 0.

Source files
------------

// File: rtl/mmio_in_pkg.sv
// Shared constants for the memory-mapped input port: register offsets, bus widths, debounce states.
// Used by mmio_input_port and input_debounce.
package mmio_in_pkg;

    localparam int REG_W   = 32;  // core data bus width
    localparam int WIN_LSB = 4;   // 16-byte window: addr[31:4] selects the block
    localparam int OFF_LSB = 2;   // word offset lives in addr[3:2]
    localparam int OFF_W   = 2;

    localparam logic [OFF_W-1:0] OFF_SW   = 2'd0;
    localparam logic [OFF_W-1:0] OFF_BTN  = 2'd1;
    localparam logic [OFF_W-1:0] OFF_EDGE = 2'd2;
    localparam logic [OFF_W-1:0] OFF_MASK = 2'd3;

    typedef enum logic {
        DB_IDLE,
        DB_COUNT
    } db_state_e;

endpackage

// File: rtl/input_debounce.sv
// One push button: two-flop synchroniser, stability counter, debounced level and a
// one-cycle rise pulse on the cycle the debounced level goes 0->1.
module input_debounce
    import mmio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic deb,
    output logic rise
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    db_state_e        state;

    assign sync = sync_q[1];
    assign deb  = deb_q;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    // The FSM state is implied by whether the synchronised pin disagrees with the accepted level.
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state = (sync != deb_q) ? DB_COUNT : DB_IDLE;
        cnt_d = '0;
        deb_d = deb_q;
        rise  = 1'b0;
        case (state)
            DB_IDLE: ;
            DB_COUNT: begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = sync;
                    rise  = sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped switch/button input port on the core data bus (SW, BTN, EDGE, MASK words).
// Define MMIO_INPUT_IRQ_EN to add the MASK register and the registered press interrupt.
module mmio_input_port
    import mmio_in_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
    parameter int          N_SW            = 16,
    parameter int          N_BTN           = 5,
    parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [31:0]      addr,
    input  logic             mem_write,
    input  logic [31:0]      wdata,
    output logic             sel,
    output logic [31:0]      rdata,
    output logic             irq
);

    logic [N_SW-1:0]  sw_meta, sw_sync;
    logic [N_BTN-1:0] btn_deb, btn_rise;
    logic [N_BTN-1:0] edge_q, edge_clr;
    logic [OFF_W-1:0] off;
    logic             wr_en;
    logic             unused_bits;

    assign sel   = (addr[REG_W-1:WIN_LSB] == BASE_ADDR[REG_W-1:WIN_LSB]);
    assign off   = addr[OFF_LSB +: OFF_W];
    assign wr_en = mem_write && sel;

    // Byte lane and store data above the button field carry no meaning here.
    assign unused_bits = ^{addr[OFF_LSB-1:0], wdata[REG_W-1:N_BTN]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        input_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .pin   (btn_i[i]),
            .deb   (btn_deb[i]),
            .rise  (btn_rise[i])
        );
    end

    // A press landing on the same edge as its write-1-to-clear keeps the flag set.
    assign edge_clr = (wr_en && off == OFF_EDGE) ? wdata[N_BTN-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_q <= '0;
        else        edge_q <= (edge_q & ~edge_clr) | btn_rise;
    end

`ifdef MMIO_INPUT_IRQ_EN
    logic [N_BTN-1:0] mask_q;
    logic             irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && off == OFF_MASK) mask_q <= wdata[N_BTN-1:0];
            irq_q <= |(edge_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_SW:   rdata[N_SW-1:0]  = sw_sync;
                OFF_BTN:  rdata[N_BTN-1:0] = btn_deb;
                OFF_EDGE: rdata[N_BTN-1:0] = edge_q;
                OFF_MASK: begin
`ifdef MMIO_INPUT_IRQ_EN
                    rdata[N_BTN-1:0] = mask_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed self-checking bench for mmio_input_port, built with DEBOUNCE_CYCLES=4.
// Build with MMIO_INPUT_IRQ_EN defined to exercise MASK and irq.
module tb_mmio_input_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_i;
    logic [4:0]  btn_i;
    logic [31:0] addr;
    logic        mem_write;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MMIO_INPUT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mmio_input_port #(
        .BASE_ADDR       (32'h0000_0100),
        .N_SW            (16),
        .N_BTN           (5),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_i      (sw_i),
        .btn_i     (btn_i),
        .addr      (addr),
        .mem_write (mem_write),
        .wdata     (wdata),
        .sel       (sel),
        .rdata     (rdata),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        mem_write = 1'b0;
        addr      = a;
        #1;
        check(tag, rdata, exp);
    endtask

    // Store occupies exactly one clock edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        wdata     = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_i      = '0;
        btn_i     = '0;
        addr      = 32'h0000_0100;
        mem_write = 1'b0;
        wdata     = '0;
        tick(2);

        // Reset state
        rd(32'h100, 32'h0, "rst_sw");
        rd(32'h104, 32'h0, "rst_btn");
        rd(32'h108, 32'h0, "rst_edge");
        rd(32'h10C, 32'h0, "rst_mask");
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // Switch synchroniser
        sw_i = 16'hA5C3;
        tick(1);
        rd(32'h100, 32'h0, "sw_after_1_edge");
        tick(2);
        rd(32'h100, 32'h0000_A5C3, "sw_synced");
        check("sw_sel", 32'(sel), 32'h1);
        rd(32'h103, 32'h0000_A5C3, "sw_byte_lane_ignored");

        // Debounce accept: sync takes 2 edges, count 0->3 takes 3, accept on the 6th
        btn_i[0] = 1'b1;
        tick(5);
        rd(32'h104, 32'h0, "btn0_count3");
        tick(1);
        rd(32'h104, 32'h1, "btn0_accepted");
        rd(32'h108, 32'h1, "edge0_set");

        // Glitch reject
        btn_i[1] = 1'b1;
        tick(2);
        btn_i[1] = 1'b0;
        tick(6);
        rd(32'h104, 32'h1, "glitch_btn");
        rd(32'h108, 32'h1, "glitch_edge");

        // A full press afterwards must take the whole debounce again
        btn_i[1] = 1'b1;
        tick(5);
        rd(32'h104, 32'h1, "btn1_not_early");
        tick(1);
        rd(32'h104, 32'h3, "btn1_accepted");
        rd(32'h108, 32'h3, "edge1_set");

        // Release changes BTN but sets no edge
        btn_i[1] = 1'b0;
        tick(6);
        rd(32'h104, 32'h1, "btn1_released");
        rd(32'h108, 32'h3, "release_no_edge");
        wr(32'h108, 32'h2);
        rd(32'h108, 32'h1, "w1c_bit1");

        // W1C of bit 0 on the edge btn[2] is accepted
        btn_i[2] = 1'b1;
        tick(5);
        rd(32'h108, 32'h1, "race_pre");
        wr(32'h108, 32'h1);
        rd(32'h108, 32'h4, "race_w1c_and_set");
        rd(32'h104, 32'h5, "race_btn");
        wr(32'h108, 32'h4);
        rd(32'h108, 32'h0, "w1c_bit2");

        // Set wins when W1C hits the same bit as a new press
        btn_i[2] = 1'b0;
        btn_i[3] = 1'b1;
        tick(6);
        rd(32'h104, 32'h9, "btn3_first_press");
        rd(32'h108, 32'h8, "edge3_first");
        btn_i[3] = 1'b0;
        tick(6);
        rd(32'h104, 32'h1, "btn3_released");
        btn_i[3] = 1'b1;
        tick(5);
        wr(32'h108, 32'h8);
        rd(32'h108, 32'h8, "set_wins");

        // Decode
        rd(32'h110, 32'h0, "out_of_window_hi");
        check("sel_hi", 32'(sel), 32'h0);
        rd(32'h0FC, 32'h0, "out_of_window_lo");
        check("sel_lo", 32'(sel), 32'h0);
        wr(32'h118, 32'hFFFF_FFFF);
        rd(32'h108, 32'h8, "w1c_out_of_window_ignored");
        wr(32'h100, 32'hFFFF_FFFF);
        rd(32'h100, 32'h0000_A5C3, "sw_write_ignored");
        wr(32'h104, 32'h0);
        rd(32'h104, 32'h9, "btn_write_ignored");
        wr(32'h108, 32'h8);
        rd(32'h108, 32'h0, "w1c_bit3");

        // MASK and irq (MASK absent in the default build)
        wr(32'h10C, 32'h2);
        rd(32'h10C, IRQ_EN ? 32'h2 : 32'h0, "mask_readback");
        check("irq_idle", 32'(irq), 32'h0);
        btn_i[1] = 1'b1;
        tick(6);
        rd(32'h108, 32'h2, "irq_edge1");
        check("irq_same_cycle", 32'(irq), 32'h0);
        tick(1);
        check("irq_asserted", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        wr(32'h108, 32'h2);
        check("irq_w1c_edge", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        tick(1);
        check("irq_cleared", 32'(irq), 32'h0);
        btn_i[0] = 1'b0;
        tick(6);
        btn_i[0] = 1'b1;
        tick(6);
        rd(32'h108, 32'h1, "unmasked_edge0");
        tick(2);
        check("irq_unmasked", 32'(irq), 32'h0);
        wr(32'h108, 32'h1);

        // Reset mid-count discards progress
        btn_i[4] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        rd(32'h100, 32'h0, "midrst_sw");
        rd(32'h104, 32'h0, "midrst_btn");
        rd(32'h108, 32'h0, "midrst_edge");
        rd(32'h10C, 32'h0, "midrst_mask");
        check("midrst_irq", 32'(irq), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        rd(32'h104, 32'h0, "postrst_not_early");
        rd(32'h100, 32'h0000_A5C3, "postrst_sw");
        tick(1);
        rd(32'h104, 32'h1B, "postrst_btn");
        rd(32'h108, 32'h1B, "postrst_edge");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
